// File: rtl/mul_pipe_ctrl_pkg.sv
// Shared multiply-op encodings and result FIFO sizing for the EX-stage multiply path.
package mul_pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    OpMulW   = 2'b00,
    OpMulhW  = 2'b01,
    OpMulhWu = 2'b10
  } mul_op_e;

  localparam int unsigned ResFifoDepth = 3;
  localparam int unsigned ResCntW      = 2;

  typedef logic [ResCntW-1:0] res_ptr_t;

  // Encoding 2'b11 is not a legal op and falls through as MUL_W.
  function automatic logic op_is_signed(logic [1:0] op);
    return op != OpMulhWu;
  endfunction

  function automatic logic op_sel_high(logic [1:0] op);
    return (op == OpMulhW) || (op == OpMulhWu);
  endfunction

  function automatic res_ptr_t res_ptr_inc(res_ptr_t ptr);
    return (ptr == res_ptr_t'(ResFifoDepth - 1)) ? '0 : ptr + res_ptr_t'(1);
  endfunction

endpackage

// File: rtl/mul_pipe_ctrl_if.sv
// Request/response handshake bundle between the EX stage and the multiply controller.
interface mul_pipe_ctrl_if #(
    parameter int unsigned TAG_W = 5
) ();

    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_op;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_op, in_a, in_b, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag
    );

    modport slave (
        input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag
    );

endinterface

// File: rtl/mul_res_fifo.sv
// Three-entry result FIFO holding selected product halves and their tags.
module mul_res_fifo
    import mul_pipe_ctrl_pkg::*;
#(
    parameter int unsigned DataW = 32,
    parameter int unsigned TagW  = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               wr_en,
    input  logic [DataW-1:0]   wr_data,
    input  logic [TagW-1:0]    wr_tag,
    input  logic               rd_en,
    output logic               out_valid,
    output logic [DataW-1:0]   rd_data,
    output logic [TagW-1:0]    rd_tag,
    output logic [ResCntW-1:0] count
);

    logic [DataW-1:0]   data_mem [ResFifoDepth];
    logic [TagW-1:0]    tag_mem  [ResFifoDepth];
    res_ptr_t           wr_ptr_q, rd_ptr_q;
    logic [ResCntW-1:0] count_q, count_d;
    logic               deq;

    assign out_valid = (count_q != '0);
    assign deq       = rd_en && out_valid;
    assign count     = count_q;
    assign rd_data   = out_valid ? data_mem[rd_ptr_q] : '0;
    assign rd_tag    = out_valid ? tag_mem[rd_ptr_q]  : '0;

    always_comb begin
        count_d = count_q;
        if (wr_en && !deq) begin
            count_d = count_q + ResCntW'(1);
        end else if (!wr_en && deq) begin
            count_d = count_q - ResCntW'(1);
        end
    end

    // Flush drops everything, including a dequeue or write landing in the same cycle.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= res_ptr_inc(wr_ptr_q);
            if (deq)   rd_ptr_q <= res_ptr_inc(rd_ptr_q);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_ptr_q] <= wr_data;
            tag_mem[wr_ptr_q]  <= wr_tag;
        end
    end

    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(wr_en && (count_q == ResCntW'(ResFifoDepth))));

endmodule

// File: rtl/mul_pipe_ctrl.sv
// Issue/retire control around an external 1-cycle multiplier with a buffered result path.
module mul_pipe_ctrl
    import mul_pipe_ctrl_pkg::*;
#(
    parameter int unsigned TAG_W = 5
) (
    input  logic           mul_clk,
    input  logic           reset,
    mul_pipe_ctrl_if.slave bus,
    input  logic           flush,
    output logic [31:0]    mul_a,
    output logic [31:0]    mul_b,
    output logic           mul_signed,
    input  logic [63:0]    mul_result,
    output logic           busy
);

    logic               s1_valid_q;
    logic [1:0]         s1_op_q;
    logic [TAG_W-1:0]   s1_tag_q;
    logic               accept;
    logic [ResCntW-1:0] fifo_count;
    logic [31:0]        res_half;

    assign mul_a      = bus.in_a;
    assign mul_b      = bus.in_b;
    assign mul_signed = op_is_signed(bus.in_op);

    // Reserve a FIFO slot for the op in s1 so a stalled sink can never overflow the buffer.
    assign bus.in_ready = ({1'b0, fifo_count} + {2'b00, s1_valid_q}) <= 3'd2;
    assign accept       = bus.in_valid && bus.in_ready && !flush;

    always_ff @(posedge mul_clk) begin
        if (reset || flush) begin
            s1_valid_q <= 1'b0;
        end else begin
            s1_valid_q <= accept;
        end
    end

    always_ff @(posedge mul_clk) begin
        if (accept) begin
            s1_op_q  <= bus.in_op;
            s1_tag_q <= bus.in_tag;
        end
    end

    assign res_half = op_sel_high(s1_op_q) ? mul_result[63:32] : mul_result[31:0];

    mul_res_fifo #(
        .DataW(32),
        .TagW (TAG_W)
    ) u_fifo (
        .clk      (mul_clk),
        .rst      (reset),
        .flush    (flush),
        .wr_en    (s1_valid_q),
        .wr_data  (res_half),
        .wr_tag   (s1_tag_q),
        .rd_en    (bus.out_ready),
        .out_valid(bus.out_valid),
        .rd_data  (bus.out_data),
        .rd_tag   (bus.out_tag),
        .count    (fifo_count)
    );

    assign busy = s1_valid_q || (fifo_count != '0);

endmodule

// File: doc/mul_pipe_ctrl.md
MUL_PIPE_CTRL -- requirements
Module: mul_pipe_ctrl

Interface
REQ-001 SHALL have parameter: TAG_W, 5, width of the opaque destination tag carried alongside each operation.
REQ-002 SHALL have one clock, mul_clk, and one reset, reset; reset is synchronous and active-high.
REQ-003 SHALL have ports:
- mul_clk  in  1  clock
- reset  in  1  synchronous active-high reset
- in_valid  in  1  request valid
- in_ready  out  1  request accepted when in_valid&&in_ready
- in_op  in  2  00 MUL_W (low 32, signed); 01 MULH_W (high 32, signed); 10 MULH_WU (high 32, unsigned); 11 treated as MUL_W
- in_a, in_b  in  32  operands
- in_tag  in  TAG_W  destination tag
- flush  in  1  cancel all in-flight and buffered operations
- mul_a, mul_b  out  32  operands to multiplier
- mul_signed  out  1  multiplier signedness
- mul_result  in  64  multiplier product
- out_valid  out  1  result valid
- out_ready  in  1  downstream accept
- out_data  out  32  selected result half
- out_tag  out  TAG_W  tag of out_data
- busy  out  1  any operation in flight or buffered

Function
REQ-004 The attached multiplier SHALL be treated as fixed latency 1 with no stall: operands driven in cycle N give the product on mul_result in cycle N+1.
REQ-005 mul_a=in_a, mul_b=in_b, mul_signed=(in_op!=10), all combinational and ungated.
REQ-006 Accept condition: in_valid && in_ready && !flush; an accepted op SHALL set stage register s1 (valid, op, tag) at the next edge.
REQ-007 When s1 is valid, the selected half SHALL be written into the result FIFO in that cycle: low = mul_result[31:0] for MUL_W, else mul_result[63:32].
REQ-008 Result FIFO: 3 entries, read/write pointers wrapping 2->0, occupancy count 0..3; out_valid = (count!=0); out_data/out_tag = head entry.
REQ-009 in_ready = (count + s1.valid <= 2); SHALL not depend combinationally on out_ready or in_valid.
REQ-010 Simultaneous FIFO write and dequeue (out_valid&&out_ready) SHALL leave count unchanged; pointers both advance.
REQ-011 Sustained throughput with out_ready=1 SHALL be one op per cycle; latency from accept to out_valid = 2 cycles.
REQ-012 FIFO SHALL never overflow; write while count==3 is an assertion failure.
REQ-013 flush SHALL, at the next edge, clear s1.valid, count and both pointers; no operation accepted in a flush cycle; dequeue in a flush cycle is discarded.
REQ-014 out_data and out_tag SHALL be 0 whenever out_valid=0.
REQ-015 busy = s1.valid || (count!=0).
REQ-016 Results SHALL leave in acceptance order.

Reset
REQ-017 While reset=1 at an edge: s1.valid=0, count=0, pointers=0; outputs after that edge: in_ready=1, out_valid=0, out_data=0, out_tag=0, busy=0.
REQ-018 Reset mid-operation SHALL discard all in-flight and buffered results; none may appear after reset deasserts.
REQ-019 FIFO data storage SHALL need no reset.

Structure
REQ-020 Op encodings (MUL_W, MULH_W, MULH_WU) and FIFO depth 3 SHALL live in the shared CPU package used by the EX stage decoder.
REQ-021 The result FIFO SHALL be one sub-module, mul_res_fifo; the multiplier SHALL be instantiated outside this block.

Verification
REQ-022 MUL_W a=0xFFFFFFFF b=0x00000002 tag=3 -> out_data=0xFFFFFFFE, tag=3, out_valid 2 cycles after accept.
REQ-023 MULH_W a=b=0x80000000 -> 0x40000000; MULH_WU a=b=0xFFFFFFFF -> 0xFFFFFFFE; MULH_W same -> 0x00000000.
REQ-024 out_ready=0, 5 back-to-back requests -> exactly 3 accepted, in_ready=0, count=3; release out_ready -> 3 results in order, then remaining accepted.
REQ-025 Continuous issue of 8 ops with out_ready=1 -> in_ready stays 1, 8 results on consecutive cycles; pointers wrap twice.
REQ-026 flush with s1 valid and count=2 -> next cycle out_valid=0, busy=0; subsequent op tag=7 returns correctly.
REQ-027 reset asserted with 2 ops buffered -> after release no result emitted, out_valid=0, in_ready=1.
